// File: rtl/aes_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aes_ctrl_pkg
// Shared definitions for the AES round-control blocks: the controller FSM
// state type, the round count and the round-constant seeds / reduction
// polynomial used by the GF(2^8) helpers.
// -----------------------------------------------------------------------------
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_t;

  localparam logic [3:0] NUM_ROUNDS     = 4'd10;
  localparam logic [7:0] RCON_FIRST_ENC = 8'h01;  // rcon of round 1 (encrypt)
  localparam logic [7:0] RCON_FIRST_DEC = 8'h36;  // rcon of round 10 (decrypt)
  localparam logic [7:0] POLY_LOW       = 8'h1b;  // x^8 = x^4+x^3+x+1 (mod p)

endpackage

// File: rtl/gf_inv_xtime.sv
// -----------------------------------------------------------------------------
// gf_inv_xtime
// Combinational inverse of xtime in GF(2^8): divides the input by x modulo
// the AES polynomial, so xtime(inv_xtime(x)) == x for every byte.
//   i_x : input byte
//   o_y : i_x / x in GF(2^8)
// -----------------------------------------------------------------------------
module gf_inv_xtime
  import aes_ctrl_pkg::*;
(
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);

  // An odd input means the value came from a reduction step: undo the
  // polynomial XOR first, then restore the shifted-out top bit.
  assign o_y = i_x[0] ? (((i_x ^ POLY_LOW) >> 1) | 8'h80) : (i_x >> 1);

endmodule

// File: rtl/aes_inv_rcon_ctrl.sv
// -----------------------------------------------------------------------------
// aes_inv_rcon_ctrl
// Round controller for the inverse AES key schedule. On start it walks
// rounds 10..1, holding each round for LATENCY cycles, and presents the
// matching round constant (0x36 down to 0x01) to the datapath.
//   clk        : rising-edge clock
//   nrst       : synchronous active-low reset
//   start      : begin a 10-round schedule (sampled only in IDLE)
//   abort      : cancel the current schedule (wins over start)
//   busy       : high while rounds are running
//   rcon       : round constant of the current round, 0x00 otherwise
//   round      : current round 10..1 while running, 0 otherwise
//   rcon_valid : strobe on the cycle the last pipeline stage consumes rcon
//   last_round : high while round 1 is running
//   done       : one-cycle pulse after round 1 completes
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module aes_inv_rcon_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int LATENCY = 4  // pipeline stages per round, 1..16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic [7:0] rcon,
  output logic [3:0] round,
  output logic       rcon_valid,
  output logic       last_round,
  output logic       done
);

  localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  ctrl_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_round, w_round_nxt;
  logic [7:0]       r_rcon, w_rcon_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_rcon_valid, w_rcon_valid_nxt;
  logic             r_last_round, w_last_round_nxt;
  logic             r_done, w_done_nxt;
  logic [7:0]       w_rcon_prev;

  gf_inv_xtime u_inv_xtime (
    .i_x (r_rcon),
    .o_y (w_rcon_prev)
  );

  // NOTE: every signal gets its hold value before the case so that no path
  // leaves one unassigned -- otherwise the tool infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_round_nxt = r_round;
    w_rcon_nxt  = r_rcon;

    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_round_nxt = NUM_ROUNDS;
          w_rcon_nxt  = RCON_FIRST_DEC;
        end
      end

      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_round_nxt = '0;
          w_rcon_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (r_round > 4'd1) begin
            w_round_nxt = r_round - 4'd1;
            w_rcon_nxt  = w_rcon_prev;
          end else begin
            w_state_nxt = ST_DONE;
            w_round_nxt = '0;
            w_rcon_nxt  = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // Leaves unconditionally; start here is dropped, abort changes nothing.
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_round_nxt = '0;
        w_rcon_nxt  = '0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_round_nxt = '0;
        w_rcon_nxt  = '0;
      end
    endcase

    // Outputs are registered copies of what the next cycle will look like.
    w_busy_nxt       = (w_state_nxt == ST_RUN);
    w_rcon_valid_nxt = w_busy_nxt && (w_cnt_nxt == CNT_LAST);
    w_last_round_nxt = w_busy_nxt && (w_round_nxt == 4'd1);
    w_done_nxt       = (w_state_nxt == ST_DONE);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_round      <= '0;
      r_rcon       <= '0;
      r_busy       <= 1'b0;
      r_rcon_valid <= 1'b0;
      r_last_round <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_round      <= w_round_nxt;
      r_rcon       <= w_rcon_nxt;
      r_busy       <= w_busy_nxt;
      r_rcon_valid <= w_rcon_valid_nxt;
      r_last_round <= w_last_round_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign busy       = r_busy;
  assign rcon       = r_rcon;
  assign round      = r_round;
  assign rcon_valid = r_rcon_valid;
  assign last_round = r_last_round;
  assign done       = r_done;

endmodule

// File: tb/tb_aes_inv_rcon_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_rcon_ctrl
// Drives a LATENCY=4 and a LATENCY=1 controller from the same start/abort/
// nrst stimulus (directed scenarios then random) and compares both against
// an elapsed-cycle model: each run is described only by how many cycles
// have passed since its start was accepted. Also checks gf_inv_xtime over
// all 256 inputs.
// -----------------------------------------------------------------------------
module tb_aes_inv_rcon_ctrl;

  logic clk = 1'b0;
  logic nrst, start, abort;

  logic       busy4, rv4, last4, done4;
  logic [7:0] rcon4;
  logic [3:0] round4;
  logic       busy1, rv1, last1, done1;
  logic [7:0] rcon1;
  logic [3:0] round1;

  logic [7:0] gx, gy;

  int checks = 0;
  int errors = 0;

  // Model: 0 = idle, 1..10*L = k-th cycle of the run, 10*L+1 = done cycle.
  int k4 = 0;
  int k1 = 0;

  logic [7:0] rcon_tbl [10] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  always #5 clk = ~clk;

  aes_inv_rcon_ctrl #(.LATENCY(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .busy(busy4), .rcon(rcon4), .round(round4),
    .rcon_valid(rv4), .last_round(last4), .done(done4)
  );

  aes_inv_rcon_ctrl #(.LATENCY(1)) u_dut1 (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .busy(busy1), .rcon(rcon1), .round(round1),
    .rcon_valid(rv1), .last_round(last1), .done(done1)
  );

  gf_inv_xtime u_gf (.i_x(gx), .o_y(gy));

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int next_k(input int k, input int lat,
                                input logic n, input logic s, input logic a);
    if (!n)              return 0;
    if (k == 0)          return (s && !a) ? 1 : 0;
    if (k <= 10 * lat)   return a ? 0 : k + 1;
    return 0;
  endfunction

  task automatic check_dut(input string nm, input int k, input int lat,
                           input logic b, input logic [7:0] rc,
                           input logic [3:0] rd, input logic v,
                           input logic l, input logic d);
    logic       e_b, e_v, e_l, e_d;
    logic [7:0] e_rc;
    logic [3:0] e_rd;
    int         idx;
    e_b = 0; e_v = 0; e_l = 0; e_d = 0; e_rc = 8'h00; e_rd = 4'd0;
    if (k >= 1 && k <= 10 * lat) begin
      idx  = (k - 1) / lat;
      e_b  = 1;
      e_rd = 4'(10 - idx);
      e_rc = rcon_tbl[idx];
      e_v  = ((k - 1) % lat) == lat - 1;
      e_l  = (idx == 9);
    end else if (k == 10 * lat + 1) begin
      e_d = 1;
    end
    check({nm, ".busy"},       32'(b),  32'(e_b));
    check({nm, ".rcon"},       32'(rc), 32'(e_rc));
    check({nm, ".round"},      32'(rd), 32'(e_rd));
    check({nm, ".rcon_valid"}, 32'(v),  32'(e_v));
    check({nm, ".last_round"}, 32'(l),  32'(e_l));
    check({nm, ".done"},       32'(d),  32'(e_d));
  endtask

  // One clock: drive inputs (we are just after a negedge), let the edge
  // happen, advance the model, and compare on the following negedge.
  task automatic step(input logic n, input logic s, input logic a);
    nrst = n; start = s; abort = a;
    @(posedge clk);
    k4 = next_k(k4, 4, n, s, a);
    k1 = next_k(k1, 1, n, s, a);
    @(negedge clk);
    check_dut("L4", k4, 4, busy4, rcon4, round4, rv4, last4, done4);
    check_dut("L1", k1, 1, busy1, rcon1, round1, rv1, last1, done1);
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; abort = 1'b0; gx = 8'h00;

    // Exhaustive inverse-xtime round trip.
    for (int x = 0; x < 256; x++) begin
      gx = 8'(x);
      #1;
      check("gf_roundtrip", 32'(xtime(gy)), 32'(x));
    end

    @(negedge clk);
    // Reset state, with start/abort noise that reset must override.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);

    // Start on the first edge after reset release; full run for both.
    step(1'b1, 1'b1, 1'b0);
    repeat (45) step(1'b1, 1'b0, 1'b0);

    // Abort during round 5 of the LATENCY=4 run, then restart.
    step(1'b1, 1'b1, 1'b0);
    repeat (21) step(1'b1, 1'b0, 1'b0);
    check("abort_at_rcon10", 32'(rcon4), 32'h10);
    step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (45) step(1'b1, 1'b0, 1'b0);

    // Start re-pulsed during the run and on the done cycle.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 44; i++)
      step(1'b1, (i % 5 == 0) || (k4 == 41), 1'b0);
    repeat (45) step(1'b1, 1'b0, 1'b0);

    // One-cycle reset mid-run, then start+abort together in idle.
    step(1'b1, 1'b1, 1'b0);
    repeat (15) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 63) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
